// File: rtl/driver_seq_cntrl_if.sv
// Slave register bus between the host and driver_seq_cntrl.
interface driver_seq_cntrl_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       slave_addr;
    logic              slave_rd;
    logic              slave_wr;
    logic [DATA_W-1:0] slave_data_in;
    logic [DATA_W-1:0] slave_data_out;
    logic              slave_rd_valid;

    modport master (
        output slave_addr, slave_rd, slave_wr, slave_data_in,
        input  slave_data_out, slave_rd_valid
    );

    modport slave (
        input  slave_addr, slave_rd, slave_wr, slave_data_in,
        output slave_data_out, slave_rd_valid
    );
endinterface

// File: rtl/driver_seq_cntrl.sv
// Register-mapped pattern driver controller: program FSM with drain-on-end,
// consecutive-address burst sequencer with FIFO backpressure, sticky status
// with interrupt, and monitor-bin readback.
module driver_seq_cntrl #(
    parameter int DATA_W        = 32,
    parameter int CNT_W         = 16,
    parameter int ADDR_MON_BINS = 16,
    parameter int VCTR_MON_BINS = 16,
    parameter int CONSEC_W      = 8,
    parameter int ADDR_STRIDE   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    driver_seq_cntrl_if.slave              sbus,
    input  logic [CNT_W-1:0]               addr_cycle_cnt,
    input  logic [CNT_W-1:0]               vctr_cycle_cnt,
    input  logic [CNT_W-1:0]               words_in_addr_fifo,
    input  logic [CNT_W-1:0]               words_in_vctr_fifo,
    input  logic [ADDR_MON_BINS*CNT_W-1:0] addr_mon_cnts,
    input  logic [VCTR_MON_BINS*CNT_W-1:0] vctr_mon_cnts,
    input  logic                           addr_fifo_full,
    output logic [DATA_W-1:0]              addr_fifo_din,
    output logic                           addr_fifo_wr,
    output logic                           run_program,
    output logic                           end_program,
    output logic                           abort_program,
    output logic                           freeze_addr_fifo,
    output logic                           freeze_vctr_fifo,
    output logic                           active_program,
    output logic                           irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int REM_W = CONSEC_W + 1;

    localparam logic [31:0] A_ADDR_FIFO = 32'h0000_0000;
    localparam logic [31:0] A_CTRL      = 32'h0000_0004;
    localparam logic [31:0] A_STATUS    = 32'h0000_0100;
    localparam logic [31:0] A_ACNT      = 32'h0000_0104;
    localparam logic [31:0] A_AWORDS    = 32'h0000_0108;
    localparam logic [31:0] A_VCNT      = 32'h0000_010C;
    localparam logic [31:0] A_VWORDS    = 32'h0000_0110;
    localparam logic [19:0] A_AMON_PG   = 20'h00011;
    localparam logic [19:0] A_VMON_PG   = 20'h00012;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     base_q, base_d;
    logic [CONSEC_W-1:0]   consec_q, consec_d;
    logic                  send_q, send_d;
    logic                  irq_en_q, irq_en_d;
    logic                  frz_addr_q, frz_addr_d;
    logic                  frz_vctr_q, frz_vctr_d;
    logic                  drop_q, drop_d;
    logic                  done_q, done_d;
    logic                  abrt_q, abrt_d;
    logic                  run_pls_q, run_pls_d;
    logic                  end_pls_q, end_pls_d;
    logic                  abort_pls_q, abort_pls_d;
    logic                  seq_busy_q, seq_busy_d;
    logic [DATA_W-1:0]     seq_word_q, seq_word_d;
    logic [REM_W-1:0]      seq_rem_q, seq_rem_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]     rd_val;

    logic wr_fifo, wr_ctrl, wr_status;
    logic cmd_abort, cmd_end, cmd_run;
    logic seq_push, seq_drop;
    logic unused_bits;

    assign wr_fifo   = sbus.slave_wr && (sbus.slave_addr == A_ADDR_FIFO);
    assign wr_ctrl   = sbus.slave_wr && (sbus.slave_addr == A_CTRL);
    assign wr_status = sbus.slave_wr && (sbus.slave_addr == A_STATUS);

    // Higher-priority commands in the same write mask the lower ones.
    assign cmd_abort = wr_ctrl & sbus.slave_data_in[2];
    assign cmd_end   = wr_ctrl & sbus.slave_data_in[1] & ~sbus.slave_data_in[2];
    assign cmd_run   = wr_ctrl & sbus.slave_data_in[0] & ~sbus.slave_data_in[1]
                       & ~sbus.slave_data_in[2];

    // A word leaves only when the FIFO can take it in this very cycle, so a
    // stall simply holds the current word: nothing lost, nothing repeated.
    assign seq_push = seq_busy_q & ~addr_fifo_full & ~frz_addr_q;
    assign seq_drop = wr_fifo & seq_busy_q;

    assign unused_bits = ^sbus.slave_data_in;

    // State and register file flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            consec_q    <= '0;
            send_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            frz_addr_q  <= 1'b0;
            frz_vctr_q  <= 1'b0;
            drop_q      <= 1'b0;
            done_q      <= 1'b0;
            abrt_q      <= 1'b0;
            run_pls_q   <= 1'b0;
            end_pls_q   <= 1'b0;
            abort_pls_q <= 1'b0;
            seq_busy_q  <= 1'b0;
            seq_word_q  <= '0;
            seq_rem_q   <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            consec_q    <= consec_d;
            send_q      <= send_d;
            irq_en_q    <= irq_en_d;
            frz_addr_q  <= frz_addr_d;
            frz_vctr_q  <= frz_vctr_d;
            drop_q      <= drop_d;
            done_q      <= done_d;
            abrt_q      <= abrt_d;
            run_pls_q   <= run_pls_d;
            end_pls_q   <= end_pls_d;
            abort_pls_q <= abort_pls_d;
            seq_busy_q  <= seq_busy_d;
            seq_word_q  <= seq_word_d;
            seq_rem_q   <= seq_rem_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    // CTRL fields, sticky status and program FSM next state / pulses.
    always_comb begin
        state_d     = state_q;
        consec_d    = consec_q;
        send_d      = send_q;
        irq_en_d    = irq_en_q;
        frz_addr_d  = frz_addr_q;
        frz_vctr_d  = frz_vctr_q;
        drop_d      = drop_q;
        done_d      = done_q;
        abrt_d      = abrt_q;
        run_pls_d   = 1'b0;
        end_pls_d   = 1'b0;
        abort_pls_d = 1'b0;

        if (wr_ctrl) begin
            consec_d   = sbus.slave_data_in[8 +: CONSEC_W];
            send_d     = sbus.slave_data_in[7];
            irq_en_d   = sbus.slave_data_in[5];
            frz_vctr_d = sbus.slave_data_in[4];
            frz_addr_d = sbus.slave_data_in[3];
        end

        // Clear first so a set landing in the same cycle wins.
        if (wr_status) begin
            drop_d = drop_d & ~sbus.slave_data_in[3];
            done_d = done_d & ~sbus.slave_data_in[4];
            abrt_d = abrt_d & ~sbus.slave_data_in[5];
        end

        if (seq_drop)
            drop_d = 1'b1;

        if (cmd_abort) begin
            state_d     = S_IDLE;
            abort_pls_d = 1'b1;
            abrt_d      = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cmd_run) begin
                        state_d   = S_ACTIVE;
                        run_pls_d = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (cmd_end)
                        state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (!seq_busy_q && (words_in_addr_fifo == '0)) begin
                        state_d   = S_DONE;
                        end_pls_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Burst sequencer: load on ADDR_FIFO write, step on each accepted push.
    always_comb begin
        base_d     = base_q;
        seq_busy_d = seq_busy_q;
        seq_word_d = seq_word_q;
        seq_rem_d  = seq_rem_q;

        if (wr_fifo && !seq_busy_q) begin
            base_d     = sbus.slave_data_in;
            seq_word_d = sbus.slave_data_in;
            seq_rem_d  = send_q ? ({1'b0, consec_q} + REM_W'(1)) : REM_W'(1);
            seq_busy_d = 1'b1;
        end else if (seq_push) begin
            seq_word_d = seq_word_q + DATA_W'(ADDR_STRIDE);
            seq_rem_d  = seq_rem_q - REM_W'(1);
            if (seq_rem_q == REM_W'(1))
                seq_busy_d = 1'b0;
        end

        if (cmd_abort) begin
            seq_busy_d = 1'b0;
            seq_rem_d  = '0;
        end
    end

    // Read mux from pre-write register values; data holds between reads.
    always_comb begin
        rd_val    = '0;
        rd_data_d = rd_data_q;
        rd_vld_d  = sbus.slave_rd;

        case (sbus.slave_addr)
            A_ADDR_FIFO: rd_val = base_q;
            A_CTRL:      rd_val = DATA_W'({consec_q, send_q, 1'b0, irq_en_q,
                                           frz_vctr_q, frz_addr_q, 3'b000});
            A_STATUS:    rd_val = DATA_W'({abrt_q, done_q, drop_q, seq_busy_q,
                                           state_q});
            A_ACNT:      rd_val = DATA_W'(addr_cycle_cnt);
            A_AWORDS:    rd_val = DATA_W'(words_in_addr_fifo);
            A_VCNT:      rd_val = DATA_W'(vctr_cycle_cnt);
            A_VWORDS:    rd_val = DATA_W'(words_in_vctr_fifo);
            default:     rd_val = '0;
        endcase

        if (sbus.slave_addr[1:0] == 2'b00) begin
            if (sbus.slave_addr[31:12] == A_AMON_PG) begin
                for (int i = 0; i < ADDR_MON_BINS; i++)
                    if (sbus.slave_addr[11:2] == 10'(i))
                        rd_val = DATA_W'(addr_mon_cnts[i*CNT_W +: CNT_W]);
            end
            if (sbus.slave_addr[31:12] == A_VMON_PG) begin
                for (int i = 0; i < VCTR_MON_BINS; i++)
                    if (sbus.slave_addr[11:2] == 10'(i))
                        rd_val = DATA_W'(vctr_mon_cnts[i*CNT_W +: CNT_W]);
            end
        end

        if (sbus.slave_rd)
            rd_data_d = rd_val;
    end

    assign sbus.slave_data_out = rd_data_q;
    assign sbus.slave_rd_valid = rd_vld_q;
    assign addr_fifo_din       = seq_word_q;
    assign addr_fifo_wr        = seq_push;
    assign run_program         = run_pls_q;
    assign end_program         = end_pls_q;
    assign abort_program       = abort_pls_q;
    assign freeze_addr_fifo    = frz_addr_q;
    assign freeze_vctr_fifo    = frz_vctr_q;
    assign active_program      = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign irq                 = irq_en_q & (done_q | drop_q | abrt_q);

endmodule

// File: doc/driver_seq_cntrl.md
# driver_seq_cntrl

Parametrised second-generation register-mapped controller for the pattern driver. It sits between the slave register bus and the address/vector FIFOs. It adds four things to the flat register decode: a program state machine with drain-on-end, a consecutive-address burst sequencer with FIFO backpressure, sticky status with interrupt, and width/bin-count parameters for the monitor readback.

## Interface
- `DATA_W`, 32: slave data and address FIFO word width (>= 16)
- `CNT_W`, 16: width of cycle counts, FIFO levels and monitor bins (<= DATA_W)
- `ADDR_MON_BINS`, 16: number of address monitor bins
- `VCTR_MON_BINS`, 16: number of vector monitor bins
- `CONSEC_W`, 8: width of the burst length field
- `ADDR_STRIDE`, 4: increment between consecutive burst addresses

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `slave_addr`  in  32  register byte address
- `slave_rd` / `slave_wr`  in  1  single-cycle read / write strobes
- `slave_data_in`  in  DATA_W  write data
- `slave_data_out`  out  DATA_W  registered read data
- `slave_rd_valid`  out  1  pulses with `slave_data_out`
- `addr_cycle_cnt`, `vctr_cycle_cnt`, `words_in_addr_fifo`, `words_in_vctr_fifo`  in  CNT_W  status inputs
- `addr_mon_cnts`  in  ADDR_MON_BINS*CNT_W  flat bus; bin i is at [i*CNT_W +: CNT_W]
- `vctr_mon_cnts`  in  VCTR_MON_BINS*CNT_W  flat bus, same packing
- `addr_fifo_full`  in  1  address FIFO cannot accept a word
- `addr_fifo_din`  out  DATA_W  FIFO write data
- `addr_fifo_wr`  out  1  FIFO push strobe
- `run_program`, `end_program`, `abort_program`  out  1  one-cycle event pulses
- `freeze_addr_fifo`, `freeze_vctr_fifo`  out  1  level outputs from CTRL
- `active_program`  out  1  high in ACTIVE or DRAIN
- `irq`  out  1  level interrupt

## Operation
- Register map (byte addresses). Unmapped reads return 0.
  - 0x0000 ADDR_FIFO, W: loads the burst base. R: last base written.
  - 0x0004 CTRL, R/W:
    - [15:8] consec_count
    - [7] send_consec
    - [5] irq_en
    - [4] freeze_vctr
    - [3] freeze_addr
    - [2] abort, [1] end, [0] run: self-clearing commands; they read back 0.
  - 0x0100 STATUS:
    - R: [1:0] state, [2] seq_busy, [3] drop_sticky, [4] done_sticky, [5] abort_sticky.
    - W: write-1-to-clear on bits [5:3].
  - 0x0104 / 0x0108 / 0x010C / 0x0110: addr_cycle_cnt, words_in_addr_fifo, vctr_cycle_cnt, words_in_vctr_fifo, zero-extended.
  - 0x0001_1000 + 4i: address bin i. 0x0001_2000 + 4i: vector bin i. Bins at i >= BINS, or non-word-aligned addresses, return 0.
- Burst sequencer:
  - A write to 0x0000 pushes the base word.
  - If send_consec=1, it then pushes base+k*ADDR_STRIDE for k = 1..consec_count, giving consec_count+1 words total. Additions wrap modulo 2^DATA_W.
  - The sequencer pushes one word per cycle while `addr_fifo_full`=0 and freeze_addr=0, and holds otherwise. No word is lost or duplicated across a stall.
  - A write to 0x0000 while seq_busy is dropped and sets drop_sticky.
- State machine (encoding IDLE=0, ACTIVE=1, DRAIN=2, DONE=3):
  - IDLE/DONE → ACTIVE on a run command; `run_program` pulses.
  - ACTIVE → DRAIN on an end command.
  - DRAIN → DONE when seq_busy=0 and words_in_addr_fifo=0; `end_program` pulses and done_sticky is set.
  - Any state → IDLE on an abort command. This flushes the sequencer (seq_busy→0), pulses `abort_program` and sets abort_sticky.
  - A run command in ACTIVE or DRAIN is ignored. An end command outside ACTIVE is ignored.
- Command priority within one CTRL write: abort > end > run.
- `irq` = irq_en & (done_sticky | drop_sticky | abort_sticky).
- Read and write to the same register in one cycle: the read returns the pre-write value. A W1C in the same cycle as a set leaves the bit set.

## Timing
- Reset: every output, every register and the sticky bits are 0; state is IDLE; the sequencer is idle.
- Read latency is 1 cycle: `slave_data_out` and `slave_rd_valid` are valid on the edge after `slave_rd`. `slave_data_out` holds its value between reads.
- ADDR_FIFO write at edge N with the FIFO not full: `addr_fifo_wr`=1 with the base word at N+1. Burst word k follows at N+1+k when there is no stall.
- CTRL write at edge N: the freeze levels and `run_program`/`abort_program` change at N+1. State changes at N+1.
- DRAIN→DONE: `end_program` pulses on the cycle after the drain condition is sampled.
- Reset asserted mid-burst or mid-drain: outputs clear asynchronously. No push occurs after reset deasserts until a new ADDR_FIFO write.

## Test plan
- Reset, then read 0x0004, 0x0100, 0x0001_1000 → all 0. `irq`, `active_program`, `addr_fifo_wr` are 0.
- CTRL=0x0000_0380 (count 3, send_consec), write 0x0000=0x1000 → pushes 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles. Hold `addr_fifo_full` high for 2 cycles mid-burst → same 4 words, no duplicates.
- Write 0x0000 again during that burst → write dropped. STATUS[3]=1. With irq_en=1, `irq`=1. W1C STATUS=0x8 → `irq`=0.
- CTRL run=1 → `run_program` 1 cycle, state 1. CTRL end=1 with words_in_addr_fifo=5 → state 2. Drive level to 0 → `end_program` pulse, state 3, STATUS[4]=1.
- CTRL write 0x0000_0007 (abort+end+run) in ACTIVE → state 0, `abort_program` pulse only, STATUS[5]=1.
- ADDR_MON_BINS=16 with bin 3=0xBEEF: read 0x0001_100C → 0x0000_BEEF. Read 0x0001_1040 → 0. Read 0x0001_1002 → 0.
